// File: rtl/sd_ddr_wr_packer_if.sv
// Half-word stream in, 128-bit write-FIFO port out.
// Shared by the SD reader, the packer and the DDR3 write FIFO.
interface sd_ddr_wr_packer_if;
  logic         din_valid;
  logic [15:0]  din;
  logic         din_ready;
  logic         flush;
  logic         wfifo_full;
  logic         wfifo_wr_en;
  logic [127:0] wfifo_din;

  modport master (
    output din_valid,
    output din,
    input  din_ready,
    output flush,
    output wfifo_full,
    input  wfifo_wr_en,
    input  wfifo_din
  );

  modport slave (
    input  din_valid,
    input  din,
    output din_ready,
    input  flush,
    input  wfifo_full,
    output wfifo_wr_en,
    output wfifo_din
  );
endinterface

// File: rtl/sd_ddr_wr_packer.sv
// Packs 16-bit half-words into 128-bit DDR3 burst words.
// Drives wr_load at frame start and counts words per frame.
module sd_ddr_wr_packer #(
  parameter int LOAD_HOLD = 16,
  parameter int LEN_W     = 24
) (
  input  logic             ui_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  sd_ddr_wr_packer_if.slave bus,
  output logic             wr_load,
  output logic             busy,
  output logic             load_done,
  output logic [LEN_W-1:0] word_cnt
);

  localparam int HW = $clog2(LOAD_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LOAD_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, PACK, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [127:0]       pack_q, pack_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic               wr_q, wr_d;
  logic [127:0]       wdat_q, wdat_d;
  logic               last_q, last_d;
  logic               fpend_q, fpend_d;
  logic               wr_load_q, wr_load_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rdy;
  logic               acc;
  logic               fl;
  logic               fin;

  // Next-state, lane packing and write issue.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pack_d  = pack_q;
    hold_d  = hold_q;
    wr_d    = 1'b0;
    wdat_d  = wdat_q;
    last_d  = last_q;
    fpend_d = fpend_q;
    rdy     = 1'b0;
    acc     = 1'b0;
    fl      = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = frame_len;
          cnt_d   = '0;
          idx_d   = '0;
          pack_d  = '0;
          hold_d  = '0;
          last_d  = 1'b0;
          fpend_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HOLD_MAX) begin
          hold_d  = '0;
          state_d = (len_q != '0) ? PACK : DONE;
        end
      end
      PACK: begin
        // A write in flight that closes the frame stops intake.
        fin = wr_q && (last_q || cnt_q == len_q);
        if (fin) begin
          state_d = DONE;
        end else begin
          rdy = !bus.wfifo_full;
          acc = bus.din_valid && rdy;
          fl  = bus.flush || fpend_q;
          if (fl && bus.wfifo_full) fpend_d = 1'b1;
          if (acc) begin
            pack_d[{idx_q, 4'b0000} +: 16] = bus.din;
            idx_d = idx_q + 3'd1;
          end
          if (acc && idx_q == 3'd7) begin
            wr_d   = 1'b1;
            wdat_d = pack_d;
            pack_d = '0;
            cnt_d  = cnt_q + LEN_W'(1);
            if (fl) begin
              last_d  = 1'b1;
              fpend_d = 1'b0;
            end
          end else if (fl && !bus.wfifo_full) begin
            fpend_d = 1'b0;
            if (idx_d != 3'd0) begin
              wr_d   = 1'b1;
              wdat_d = pack_d;
              pack_d = '0;
              idx_d  = '0;
              cnt_d  = cnt_q + LEN_W'(1);
              last_d = 1'b1;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_load_d = (state_d == LOAD);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      pack_q    <= '0;
      hold_q    <= '0;
      wr_q      <= 1'b0;
      wdat_q    <= '0;
      last_q    <= 1'b0;
      fpend_q   <= 1'b0;
      wr_load_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pack_q    <= pack_d;
      hold_q    <= hold_d;
      wr_q      <= wr_d;
      wdat_q    <= wdat_d;
      last_q    <= last_d;
      fpend_q   <= fpend_d;
      wr_load_q <= wr_load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.din_ready   = rdy;
  assign bus.wfifo_wr_en = wr_q;
  assign bus.wfifo_din   = wdat_q;
  assign wr_load         = wr_load_q;
  assign busy            = busy_q;
  assign load_done       = done_q;
  assign word_cnt        = cnt_q;

endmodule

// File: doc/sd_ddr_wr_packer.md
Name: sd_ddr_wr_packer

Overview:
- Upstream feeder of the DDR3 read/write controller's write-port FIFO.
- Takes 16-bit model-parameter half-words streamed from the SD reader and packs them into 128-bit words. Each 128-bit word holds 8 lanes and matches one DDR3 burst.
- Writes packed words into the write FIFO.
- Generates the frame-start `wr_load` level that the controller synchronises and edge-detects to reset its write address.
- Counts packed words against a programmed frame length and reports completion.

Parameters:
- LOAD_HOLD, 16, number of cycles `wr_load` is held high at frame start. Must be ≥ 4 so the controller's 2-stage synchroniser sees the edge.
- LEN_W, 24, width of frame length and word counter.

Ports:
- ui_clk  input  1  block clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a new frame load.
- frame_len  input  LEN_W  frame size in 128-bit words; sampled on accepted start.
- din_valid  input  1  upstream half-word valid.
- din  input  16  upstream half-word.
- din_ready  output  1  block accepts din this cycle.
- flush  input  1  end-of-stream. Zero-pads and emits a partial word.
- wfifo_full  input  1  write FIFO almost-full; asserted with ≥ 2 free entries remaining.
- wfifo_wr_en  output  1  write strobe to write FIFO.
- wfifo_din  output  128  packed word.
- wr_load  output  1  frame-start level to the DDR3 controller.
- busy  output  1  high in any state other than IDLE.
- load_done  output  1  one-cycle pulse when the frame is complete.
- word_cnt  output  LEN_W  words written in the current frame.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; lane index 0; pack register 0; hold counter 0.
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately: no load_done and no further FIFO writes.
- States: IDLE, LOAD, PACK, DONE.
- IDLE:
  - `start` latches frame_len, clears word_cnt and lane index, and moves to LOAD.
  - `start` in any other state is ignored.
- LOAD:
  - wr_load = 1 for exactly LOAD_HOLD cycles; hold counter counts 0..LOAD_HOLD-1.
  - Then: go to PACK if latched length ≠ 0, else go to DONE.
  - din_ready = 0 throughout.
- PACK:
  - din_ready = !wfifo_full.
  - A half-word is accepted when din_valid && din_ready.
  - Accepted din goes into lane[idx], bits 16*idx+15 : 16*idx; the first half-word of a word lands in bits 15:0.
  - idx increments on each accept and wraps 7→0.
  - Accept at idx == 7:
    - Next cycle: wfifo_wr_en = 1 for one cycle.
    - wfifo_din = the assembled word, including the lane-7 data.
    - The pack register is cleared for the next word.
    - word_cnt increments in the same cycle as wfifo_wr_en.
  - Output is registered, so latency from the 8th accept to wfifo_wr_en is 1 cycle.
  - Back-to-back words are allowed: one word per 8 accepts, no bubble.
  - When the write that makes word_cnt == frame_len issues: din_ready drops in that cycle, and next state is DONE.
  - flush with idx > 0 and !wfifo_full:
    - Remaining lanes are zero.
    - Word emitted next cycle; idx reset to 0; word_cnt increments.
    - After that write, go to DONE regardless of word_cnt.
  - flush with idx == 0: no write; go directly to DONE.
  - flush while wfifo_full: deferred until !wfifo_full.
  - Simultaneous flush and an accepted din: din is packed first, then flush is applied to the resulting idx.
    - Resulting idx == 0 (the din filled lane 7): only that word is written; no additional zero word.
- DONE:
  - load_done = 1 for one cycle, then IDLE.
  - word_cnt holds its value until the next start.
- wr_load is never high outside LOAD.
- wfifo_wr_en is never asserted outside PACK or the first cycle of DONE.
- Arithmetic:
  - word_cnt is unsigned LEN_W and does not wrap within a frame, because frame_len ≤ 2^LEN_W − 1.
  - Comparison is equality against the latched length.

Test Plan:
- Reset mid-PACK after 3 accepts → all outputs 0 immediately; next start with frame_len = 1 plus 8 half-words 0x0001..0x0008 → wfifo_din = 0x0008_0007_0006_0005_0004_0003_0002_0001, word_cnt = 1, load_done pulse.
- start with frame_len = 2 and continuous din_valid → wr_load high exactly 16 cycles; din_ready low during LOAD; two back-to-back wfifo_wr_en 8 cycles apart; load_done 1 cycle after the second write.
- wfifo_full asserted after the 5th half-word for 10 cycles → din_ready low for 10 cycles, no writes; resume → correct word with no lost or duplicated lanes.
- frame_len = 4 with flush after 3 half-words (0xAAAA, 0xBBBB, 0xCCCC) → one write of 0x…0000_CCCC_BBBB_AAAA with upper 80 bits zero; word_cnt = 1; load_done.
- frame_len = 0 → wr_load pulse of LOAD_HOLD cycles, then load_done; zero FIFO writes.
- start asserted while busy → ignored: frame_len unchanged, no second wr_load.
